perceptron_train_sequencer: RTL

Sequences perceptron weight training for the branch predictor. Resolved-branch training requests from EX are buffered in a small FIFO. Each request that meets the training rule is applied to the shared weight RAM as a pipelined read-modify-write, one weight per cycle. The predictor's lookup path keeps priority on the RAM read port; this block owns the write port outright.

---
 rtl/perceptron_pkg.sv | 52 +++++
 rtl/train_req_fifo.sv | 57 +++++
 rtl/perceptron_train_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_pkg
//  Description : Shared constants, FIFO entry type, FSM state type and the
//                saturating +/-1 helper for perceptron weight training.
//  Revision    : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

    localparam int c_PERCEPTRON_NUMBER = 64;
    localparam int c_HISTORY_SIZE      = 64;
    localparam int c_WEIGHT_NUMBER     = c_HISTORY_SIZE + 1;
    localparam int c_WIDTH             = 8;
    localparam int c_FIFO_DEPTH        = 4;
    // floor(1.93 * 64 + 14) = floor(137.52)
    localparam int c_THRESHOLD         = 137;

    localparam int c_IW = $clog2(c_PERCEPTRON_NUMBER);
    localparam int c_KW = $clog2(c_WEIGHT_NUMBER);
    localparam int c_YW = c_WIDTH + c_KW;

    localparam logic signed [c_WIDTH-1:0] c_W_MAX = {1'b0, {(c_WIDTH-1){1'b1}}};
    localparam logic signed [c_WIDTH-1:0] c_W_MIN = {1'b1, {(c_WIDTH-1){1'b0}}};

    // One buffered training request.
    typedef struct packed {
        logic [c_IW-1:0]          index;
        logic [c_HISTORY_SIZE-1:0] history;
        logic                     outcome;
        logic                     prediction;
        logic signed [c_YW-1:0]   y;
    } train_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } train_state_e;

    // Step a weight by +1 (up=1) or -1 (up=0), clamping at the signed limits.
    function automatic logic signed [c_WIDTH-1:0] sat_inc(
        input logic signed [c_WIDTH-1:0] w,
        input logic                      up
    );
        if (up) begin
            return (w == c_W_MAX) ? w : w + c_WIDTH'(1);
        end
        return (w == c_W_MIN) ? w : w - c_WIDTH'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/train_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : train_req_fifo
//  Description : Synchronous FIFO of training requests with full/empty flags.
//                Push and pop may happen in the same cycle. DEPTH must be a
//                power of two, at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module train_req_fifo
    import perceptron_pkg::*;
#(
    parameter int DEPTH = c_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  train_req_t i_data,
    output logic       o_full,
    input  logic       i_pop,
    output train_req_t o_head,
    output logic       o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    train_req_t       r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update on accepted push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/perceptron_train_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_train_sequencer
//  Description : Buffers resolved-branch training requests and applies each
//                qualifying one to the weight RAM as a pipelined
//                read-modify-write, one weight per cycle. Reads yield to the
//                predictor lookup; writes are never stalled.
//                Field widths of train_req_t come from the package defaults,
//                so overriding the size parameters requires matching package
//                constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module perceptron_train_sequencer
    import perceptron_pkg::*;
#(
    parameter int PERCEPTRON_NUMBER = c_PERCEPTRON_NUMBER,
    parameter int HISTORY_SIZE      = c_HISTORY_SIZE,
    parameter int WEIGHT_NUMBER     = HISTORY_SIZE + 1,
    parameter int WIDTH             = c_WIDTH,
    parameter int FIFO_DEPTH        = c_FIFO_DEPTH,
    parameter int THRESHOLD         = c_THRESHOLD
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              req_valid,
    output logic                                              req_ready,
    input  logic [$clog2(PERCEPTRON_NUMBER)-1:0]              req_index,
    input  logic [HISTORY_SIZE-1:0]                           req_history,
    input  logic                                              req_outcome,
    input  logic                                              req_prediction,
    input  logic signed [WIDTH+$clog2(WEIGHT_NUMBER)-1:0]     req_y,
    input  logic                                              lookup_req,
    output logic                                              wram_re,
    output logic [$clog2(PERCEPTRON_NUMBER)-1:0]              wram_ridx,
    output logic [$clog2(WEIGHT_NUMBER)-1:0]                  wram_rk,
    input  logic signed [WIDTH-1:0]                           wram_rdata,
    output logic                                              wram_we,
    output logic [$clog2(PERCEPTRON_NUMBER)-1:0]              wram_widx,
    output logic [$clog2(WEIGHT_NUMBER)-1:0]                  wram_wk,
    output logic signed [WIDTH-1:0]                           wram_wdata,
    output logic                                              busy,
    output logic [31:0]                                       train_count,
    output logic [31:0]                                       skip_count
);

    localparam int IW = $clog2(PERCEPTRON_NUMBER);
    localparam int KW = $clog2(WEIGHT_NUMBER);
    localparam int YW = WIDTH + KW;
    localparam int HW = $clog2(HISTORY_SIZE);
    localparam logic [KW-1:0] c_K_LAST = KW'(WEIGHT_NUMBER - 1);
    localparam logic [YW:0]   c_THR    = (YW+1)'(THRESHOLD);

    train_req_t          w_push_data;
    train_req_t          w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_train;
    logic                w_rd_issue;
    logic                w_skip;
    logic                w_done;
    logic                w_up;
    logic signed [YW:0]  w_y_ext;
    logic [YW:0]         w_y_abs;
    logic [HW-1:0]       w_hidx;
    train_state_e        w_state_nxt;

    train_state_e        r_state;
    logic [IW-1:0]       r_idx;
    logic [HISTORY_SIZE-1:0] r_hist;
    logic                r_outcome;
    logic [KW-1:0]       r_rk;
    logic                r_wr_pend;
    logic [KW-1:0]       r_wr_k;
    logic                r_wr_up;
    logic [31:0]         r_train_count;
    logic [31:0]         r_skip_count;

    assign w_push_data = '{index:      req_index,
                           history:    req_history,
                           outcome:    req_outcome,
                           prediction: req_prediction,
                           y:          req_y};

    train_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid),
        .i_data  (w_push_data),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty)
    );

    // |y| is taken one bit wider so the most negative y stays positive.
    assign w_y_ext = {w_head.y[YW-1], w_head.y};
    assign w_y_abs = w_y_ext[YW] ? -w_y_ext : w_y_ext;
    assign w_train = (w_head.prediction != w_head.outcome) || (w_y_abs <= c_THR);

    // t*x_k is +1 when target and input agree; the bias input is always +1.
    assign w_hidx = HW'(r_rk - KW'(1));
    assign w_up   = (r_rk == '0) ? r_outcome : (r_outcome == r_hist[w_hidx]);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rd_issue  = 1'b0;
        w_skip      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_train) w_state_nxt = STREAM;
                    else         w_skip      = 1'b1;
                end
            end
            STREAM: begin
                if (!lookup_req) begin
                    w_rd_issue = 1'b1;
                    if (r_rk == c_K_LAST) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Working copy of the request being trained and the read weight pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_hist    <= '0;
            r_outcome <= 1'b0;
            r_rk      <= '0;
        end else if (w_pop && w_train) begin
            r_idx     <= w_head.index;
            r_hist    <= w_head.history;
            r_outcome <= w_head.outcome;
            r_rk      <= '0;
        end else if (w_rd_issue) begin
            r_rk      <= r_rk + KW'(1);
        end
    end

    // Read-to-write pipeline stage: the write follows its read by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_pend <= 1'b0;
            r_wr_k    <= '0;
            r_wr_up   <= 1'b0;
        end else begin
            r_wr_pend <= w_rd_issue;
            r_wr_k    <= r_rk;
            r_wr_up   <= w_up;
        end
    end

    // Completed-training and skipped-request counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_train_count <= '0;
            r_skip_count  <= '0;
        end else begin
            if (w_done) r_train_count <= r_train_count + 32'd1;
            if (w_skip) r_skip_count  <= r_skip_count + 32'd1;
        end
    end

    assign req_ready   = !w_full;
    assign wram_re     = w_rd_issue;
    assign wram_ridx   = w_rd_issue ? r_idx : '0;
    assign wram_rk     = w_rd_issue ? r_rk  : '0;
    assign wram_we     = r_wr_pend;
    assign wram_widx   = r_wr_pend ? r_idx  : '0;
    assign wram_wk     = r_wr_pend ? r_wr_k : '0;
    assign wram_wdata  = r_wr_pend ? sat_inc(wram_rdata, r_wr_up) : '0;
    assign busy        = !w_empty || (r_state != IDLE);
    assign train_count = r_train_count;
    assign skip_count  = r_skip_count;

endmodule
`default_nettype wire
